// File: rtl/result_collector.sv
// result_collector: snapshots a systolic array's accumulators on DONE and streams them
// out row-major over a valid/ready handshake, flagging overruns.
module result_collector #(
  parameter int Bitwidth  = 16,
  parameter int UNITS_X   = 4,
  parameter int UNITS_Y   = 4,
  parameter int ACC_Width = 2*Bitwidth
) (
  input  logic                                        CLK,
  input  logic                                        RST,
  input  logic                                        DONE,
  input  logic [UNITS_X*UNITS_Y*ACC_Width-1:0]        RES,
  output logic [ACC_Width-1:0]                        OUT_DATA,
  output logic [(UNITS_Y > 1 ? $clog2(UNITS_Y) : 1)-1:0] OUT_ROW,
  output logic [(UNITS_X > 1 ? $clog2(UNITS_X) : 1)-1:0] OUT_COL,
  output logic                                        OUT_VALID,
  input  logic                                        OUT_READY,
  output logic                                        OUT_LAST,
  output logic                                        BUSY,
  output logic                                        OVERRUN
);
  localparam int RW = UNITS_Y > 1 ? $clog2(UNITS_Y) : 1;
  localparam int CW = UNITS_X > 1 ? $clog2(UNITS_X) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t                 state_q;
  logic [ACC_Width-1:0]   snap_q [UNITS_Y][UNITS_X];
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic                   valid_q, busy_q, overrun_q, col_end, last_w;
  always_comb begin
    col_end = col_q == CW'(UNITS_X-1);
    last_w  = col_end && (row_q == RW'(UNITS_Y-1));
    col_d   = col_end ? '0 : col_q + 1'b1;
    row_d   = col_end ? row_q + 1'b1 : row_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int r = 0; r < UNITS_Y; r++)
        for (int c = 0; c < UNITS_X; c++)
          snap_q[r][c] <= '0;
    end else if (state_q == IDLE) begin
      if (DONE) begin
        state_q <= SEND;
        row_q   <= '0;
        col_q   <= '0;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        for (int r = 0; r < UNITS_Y; r++)
          for (int c = 0; c < UNITS_X; c++)
            snap_q[r][c] <= RES[ACC_Width*(r*UNITS_X+c) +: ACC_Width];
      end
    end else begin
      if (DONE) overrun_q <= 1'b1;
      if (OUT_READY) begin
        if (last_w) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          row_q   <= '0;
          col_q   <= '0;
        end else begin
          row_q <= row_d;
          col_q <= col_d;
        end
      end
    end
  end
  // Data is forced to zero outside a frame so IDLE outputs match the reset values.
  assign OUT_DATA  = valid_q ? snap_q[row_q][col_q] : '0;
  assign OUT_ROW   = row_q;
  assign OUT_COL   = col_q;
  assign OUT_VALID = valid_q;
  assign OUT_LAST  = valid_q && last_w;
  assign BUSY      = busy_q;
  assign OVERRUN   = overrun_q;
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter Bitwidth, default 16: operand width of the systolic array.
REQ-002 Parameter UNITS_X, default 4: PE columns.
REQ-003 Parameter UNITS_Y, default 4: PE rows.
REQ-004 Parameter ACC_Width, default 2*Bitwidth: width of one accumulated result.
REQ-005 CLK  input  1  single clock; all logic on rising edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 DONE  input  1  one-cycle pulse from the array: results are final.
REQ-008 RES  input  UNITS_X*UNITS_Y*ACC_Width  all PE accumulators; element (r,c) at RES[ACC_Width*(r*UNITS_X+c) +: ACC_Width].
REQ-009 OUT_DATA  output  ACC_Width  current result word.
REQ-010 OUT_ROW  output  clog2(UNITS_Y) (min 1)  row index r of OUT_DATA.
REQ-011 OUT_COL  output  clog2(UNITS_X) (min 1)  column index c of OUT_DATA.
REQ-012 OUT_VALID  output  1  OUT_DATA/OUT_ROW/OUT_COL valid.
REQ-013 OUT_READY  input  1  downstream accepts the word.
REQ-014 OUT_LAST  output  1  high with the final word of a frame.
REQ-015 BUSY  output  1  frame capture held or draining.
REQ-016 OVERRUN  output  1  sticky: DONE arrived while BUSY.

Function
REQ-017 FSM states IDLE and SEND only; IDLE is the reset state.
REQ-018 IDLE: DONE=1 at edge k -> RES copied into an internal snapshot register, row/col counters cleared to 0, state SEND; OUT_VALID=1 and BUSY=1 from cycle k+1.
REQ-019 IDLE with DONE=0: all outputs hold reset values except OVERRUN, which holds.
REQ-020 SEND: OUT_DATA = snapshot element (OUT_ROW, OUT_COL); a transfer occurs on an edge where OUT_VALID=1 and OUT_READY=1.
REQ-021 Order row-major: c increments 0..UNITS_X-1, then wraps to 0 with r+1; UNITS_X*UNITS_Y transfers per frame.
REQ-022 OUT_VALID=1 with OUT_READY=0: OUT_DATA, OUT_ROW, OUT_COL, OUT_LAST held stable; no word dropped or repeated.
REQ-023 OUT_LAST = OUT_VALID AND r=UNITS_Y-1 AND c=UNITS_X-1.
REQ-024 Transfer of the last word -> state IDLE; OUT_VALID, BUSY, OUT_LAST low the next cycle; counters return to 0.
REQ-025 Throughput: one word per cycle with OUT_READY held high; frame drains in exactly UNITS_X*UNITS_Y cycles after entry to SEND.
REQ-026 DONE in SEND (including the last-transfer cycle): ignored; snapshot and drain unaffected; OVERRUN set to 1.
REQ-027 DONE in IDLE on the cycle after the last transfer: accepted normally as a new frame.
REQ-028 Snapshot decouples RES: RES changes during SEND do not alter transmitted data.
REQ-029 OUT_DATA passes the snapshot bits unmodified; no arithmetic, sign or truncation change.
REQ-030 OUT_DATA, OUT_ROW, OUT_COL are combinational from registered state; OUT_VALID and BUSY are registered.

Reset
REQ-031 RST=1 at any edge -> next cycle: state IDLE, OUT_VALID=0, OUT_LAST=0, BUSY=0, OVERRUN=0, OUT_ROW=0, OUT_COL=0, OUT_DATA=0, snapshot=0.
REQ-032 RST has priority over DONE and over any transfer on the same edge; a frame in progress is abandoned and not resumed.

Verification
REQ-033 Default params, RES element (r,c)=16*r+c, DONE pulse, OUT_READY=1 -> 16 consecutive words 0,1,2,3,16,17,...,51; OUT_LAST only on 51; BUSY low after it.
REQ-034 Same frame, OUT_READY toggling 1,0,1,0 -> each value appears exactly once, held stable through every stall cycle; 32 cycles total.
REQ-035 DONE at drain word 5, RES altered to all 0xFFFFFFFF -> remaining words unchanged from the original snapshot; OVERRUN=1 and stays 1 until RST.
REQ-036 RST asserted during drain word 7 with DONE also high -> next cycle OUT_VALID=0, BUSY=0, OVERRUN=0, OUT_DATA=0; no further words.
REQ-037 Back-to-back: second DONE on the cycle after OUT_LAST transfer, RES element (r,c)=100+c -> second frame 100,101,102,103 repeated for each of 4 rows; OVERRUN stays 0.
REQ-038 OUT_READY held 0 for 20 cycles after DONE -> OUT_VALID=1, word (0,0) held throughout; draining starts when OUT_READY rises.
